// File: rtl/bin2bcd_if.sv
// Handshake bundle between a binary producer and the iterative BCD converter.
// Input side: valid/ready with the binary operand x.
// Output side: valid/ready with the packed BCD result and the overflow flag.
interface bin2bcd_if #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
);
   logic                  in_valid;
   logic                  in_ready;
   logic [WIDTH-1:0]      x;
   logic                  out_valid;
   logic                  out_ready;
   logic [4*DIGITS-1:0]   bcd;
   logic                  ovf;

   // Producer/consumer side of the converter.
   modport master (
      output in_valid,
      output x,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  bcd,
      input  ovf
   );

   // Converter side.
   modport slave (
      input  in_valid,
      input  x,
      input  out_ready,
      output in_ready,
      output out_valid,
      output bcd,
      output ovf
   );
endinterface

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one shift per clock.
// A WIDTH-bit operand is accepted in IDLE, shifted WIDTH times through a
// {digits, binary} register, and the digit field is presented in HOLD until
// the consumer takes it. Bits pushed out of the top digit set a sticky
// overflow flag, leaving x mod 10^DIGITS in the digit field.
module bin2bcd_iter #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   bin2bcd_if.slave   bus
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int REG_W = BCD_W + WIDTH;
   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t             state;
   logic [REG_W-1:0]   sreg;
   logic [REG_W-1:0]   corrected;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_q;
   logic               in_ready_q;
   logic               out_valid_q;

   // Add 3 to every digit that is 5 or more. Digits stay 4 bits wide and
   // never carry into their neighbour: a corrected digit is at most 12.
   function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] d);
      logic [BCD_W-1:0] r;
      r = d;
      for (int i = 0; i < DIGITS; i++) begin
         if (d[4*i +: 4] >= 4'd5) begin
            r[4*i +: 4] = d[4*i +: 4] + 4'd3;
         end
      end
      return r;
   endfunction

   // Correction step applied to the digit field ahead of the shift.
   always_comb begin
      corrected = {add3(sreg[REG_W-1 -: BCD_W]), sreg[WIDTH-1:0]};
   end

   // Control FSM with datapath; handshake outputs are registered so they
   // depend on state alone, never on in_valid/out_ready of the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sreg        <= '0;
         cnt         <= '0;
         ovf_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  sreg       <= {{BCD_W{1'b0}}, bus.x};
                  ovf_q      <= 1'b0;
                  cnt        <= CNT_W'(WIDTH);
                  in_ready_q <= 1'b0;
                  state      <= SHIFT;
               end
            end
            SHIFT: begin
               sreg  <= {corrected[REG_W-2:0], 1'b0};
               ovf_q <= ovf_q | corrected[REG_W-1];
               cnt   <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) begin
                  out_valid_q <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: begin
               out_valid_q <= 1'b0;
               in_ready_q  <= 1'b1;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.bcd       = sreg[REG_W-1 -: BCD_W];
   assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Bench for bin2bcd_iter: four instances (8/3, 8/2, 16/5, 16/4) sharing one
// clock and reset. Expected results come from decimal arithmetic on x.
module tb_bin2bcd_iter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] xs = '0;
   logic        in_valid  [4];
   logic        out_ready [4];
   logic        in_ready_v  [4];
   logic        out_valid_v [4];
   logic [39:0] bcd_v [4];
   logic        ovf_v [4];

   int checks   = 0;
   int failures = 0;
   longint cyc  = 0;

   bin2bcd_if #(.WIDTH(8),  .DIGITS(3)) if0 ();
   bin2bcd_if #(.WIDTH(8),  .DIGITS(2)) if1 ();
   bin2bcd_if #(.WIDTH(16), .DIGITS(5)) if2 ();
   bin2bcd_if #(.WIDTH(16), .DIGITS(4)) if3 ();

   bin2bcd_iter #(.WIDTH(8),  .DIGITS(3)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   bin2bcd_iter #(.WIDTH(8),  .DIGITS(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   bin2bcd_iter #(.WIDTH(16), .DIGITS(5)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
   bin2bcd_iter #(.WIDTH(16), .DIGITS(4)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

   assign if0.in_valid = in_valid[0];  assign if0.out_ready = out_ready[0];  assign if0.x = xs[7:0];
   assign if1.in_valid = in_valid[1];  assign if1.out_ready = out_ready[1];  assign if1.x = xs[7:0];
   assign if2.in_valid = in_valid[2];  assign if2.out_ready = out_ready[2];  assign if2.x = xs[15:0];
   assign if3.in_valid = in_valid[3];  assign if3.out_ready = out_ready[3];  assign if3.x = xs[15:0];

   assign in_ready_v[0] = if0.in_ready;  assign out_valid_v[0] = if0.out_valid;
   assign in_ready_v[1] = if1.in_ready;  assign out_valid_v[1] = if1.out_valid;
   assign in_ready_v[2] = if2.in_ready;  assign out_valid_v[2] = if2.out_valid;
   assign in_ready_v[3] = if3.in_ready;  assign out_valid_v[3] = if3.out_valid;
   assign bcd_v[0] = 40'(if0.bcd);  assign ovf_v[0] = if0.ovf;
   assign bcd_v[1] = 40'(if1.bcd);  assign ovf_v[1] = if1.ovf;
   assign bcd_v[2] = 40'(if2.bcd);  assign ovf_v[2] = if2.ovf;
   assign bcd_v[3] = 40'(if3.bcd);  assign ovf_v[3] = if3.ovf;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wid(input int s);
      return (s < 2) ? 8 : 16;
   endfunction

   function automatic int digs(input int s);
      case (s)
         0: return 3;
         1: return 2;
         2: return 5;
         default: return 4;
      endcase
   endfunction

   // Decimal digits of v, lowest DIGITS of them, and whether v needs more.
   function automatic void model(input longint v, input int d,
                                 output logic [39:0] b, output logic o);
      longint p;
      p = 1;
      b = '0;
      for (int i = 0; i < d; i++) begin
         b[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      o = (v >= p);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // One conversion on instance s; out_ready held low for `hold` cycles
   // after out_valid, during which a stray in_valid/x must be ignored.
   // Entered and left at 1 time unit after a rising edge.
   task automatic convert(input int s, input logic [31:0] xv, input int hold, input string tag);
      int lat;
      logic [39:0] eb;
      logic eo;
      model(longint'(xv), digs(s), eb, eo);
      lat = 0;
      while (!in_ready_v[s] && lat < 50) begin @(posedge clk); #1; lat++; end
      chk({tag, "_idle_rdy"}, 64'(in_ready_v[s]), 64'd1);
      xs = xv;
      in_valid[s] = 1'b1;
      out_ready[s] = (hold == 0);
      @(posedge clk); #1;
      in_valid[s] = 1'b0;
      xs = $urandom;
      chk({tag, "_rdy_drop"}, 64'(in_ready_v[s]), 64'd0);
      lat = 0;
      while (!out_valid_v[s] && lat < 100) begin @(posedge clk); #1; lat++; end
      chk({tag, "_latency"}, 64'(lat), 64'(wid(s)));
      chk({tag, "_bcd"}, 64'(bcd_v[s]), 64'(eb));
      chk({tag, "_ovf"}, 64'(ovf_v[s]), 64'(eo));
      if (hold > 0) begin
         for (int h = 0; h < hold; h++) begin
            in_valid[s] = 1'b1;
            xs = 32'd7;
            @(posedge clk); #1;
            chk($sformatf("%s_hold%0d_vld", tag, h), 64'(out_valid_v[s]), 64'd1);
            chk($sformatf("%s_hold%0d_rdy", tag, h), 64'(in_ready_v[s]), 64'd0);
            chk($sformatf("%s_hold%0d_bcd", tag, h), 64'(bcd_v[s]), 64'(eb));
         end
         in_valid[s] = 1'b0;
         out_ready[s] = 1'b1;
      end
      @(posedge clk); #1;
      out_ready[s] = 1'b0;
      chk({tag, "_done_rdy"}, 64'(in_ready_v[s]), 64'd1);
      chk({tag, "_done_vld"}, 64'(out_valid_v[s]), 64'd0);
      if (hold > 0) begin
         @(posedge clk); #1;
         chk({tag, "_stray_ignored"}, 64'(in_ready_v[s]), 64'd1);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [39:0] eb;
      logic        eo;
      longint      prev;
      int          lat;
      int          bad;
      logic [31:0] rv;

      for (int i = 0; i < 4; i++) begin
         in_valid[i] = 1'b0;
         out_ready[i] = 1'b0;
      end
      #12;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("rst%0d_rdy", i), 64'(in_ready_v[i]), 64'd1);
         chk($sformatf("rst%0d_vld", i), 64'(out_valid_v[i]), 64'd0);
         chk($sformatf("rst%0d_bcd", i), 64'(bcd_v[i]), 64'd0);
         chk($sformatf("rst%0d_ovf", i), 64'(ovf_v[i]), 64'd0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed values on the default configuration.
      convert(0, 32'd255, 0, "d8_255");
      convert(0, 32'd0,   0, "d8_0");
      convert(0, 32'd99,  0, "d8_99");

      // Two-digit overflow cases.
      convert(1, 32'd199, 0, "d2_199");
      convert(1, 32'd100, 0, "d2_100");
      convert(1, 32'd99,  0, "d2_99");

      // Wider operands.
      convert(2, 32'd65535, 0, "w16d5_65535");
      convert(3, 32'd12345, 0, "w16d4_12345");

      // Backpressure with a stray request while the result is held.
      convert(0, 32'd42, 5, "bp_42");

      // Exhaustive 0..255 back-to-back, in_valid and out_ready held high.
      in_valid[0] = 1'b1;
      out_ready[0] = 1'b1;
      prev = -1;
      bad = 0;
      for (int v = 0; v < 256; v++) begin
         xs = 32'(v);
         lat = 0;
         while (!in_ready_v[0] && lat < 50) begin @(posedge clk); #1; lat++; end
         @(posedge clk); #1;
         xs = 32'(v + 1);
         lat = 0;
         while (!out_valid_v[0] && lat < 100) begin @(posedge clk); #1; lat++; end
         model(longint'(v), 3, eb, eo);
         if (out_valid_v[0] !== 1'b1 || bcd_v[0] !== eb || ovf_v[0] !== eo) bad++;
         if (v == 0 || v == 128 || v == 255) begin
            chk($sformatf("exh_bcd_%0d", v), 64'(bcd_v[0]), 64'(eb));
         end
         if (prev >= 0) begin
            if (cyc - prev != 10) bad++;
         end
         prev = cyc;
      end
      chk("exh_all_results_and_interval", 64'(bad), 64'd0);
      in_valid[0] = 1'b0;
      @(posedge clk); #1;
      out_ready[0] = 1'b0;
      @(posedge clk); #1;

      // Randomized operands on every configuration, random backpressure.
      for (int s = 0; s < 4; s++) begin
         for (int n = 0; n < 6; n++) begin
            rv = $urandom;
            if (wid(s) == 8) rv = rv & 32'h0000_00FF;
            else             rv = rv & 32'h0000_FFFF;
            convert(s, rv, int'($urandom_range(0, 3)), $sformatf("rnd_s%0d_n%0d", s, n));
         end
      end

      // Asynchronous reset in the middle of a conversion.
      xs = 32'd200;
      in_valid[0] = 1'b1;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("midrst_rdy", 64'(in_ready_v[0]), 64'd1);
      chk("midrst_vld", 64'(out_valid_v[0]), 64'd0);
      chk("midrst_bcd", 64'(bcd_v[0]), 64'd0);
      chk("midrst_ovf", 64'(ovf_v[0]), 64'd0);
      #12;
      rst_n = 1'b1;
      @(posedge clk); #1;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         if (out_valid_v[0] !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      chk("midrst_no_result", 64'(bad), 64'd0);
      convert(0, 32'd13, 0, "after_rst_13");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
